// File: rtl/spi_slave_read.sv
// SPI slave receiver: oversamples sck/mosi/csn on clk, deserialises MSB-first
// words of DATA_WIDTH bits and presents them on a valid/ready interface.
module spi_slave_read #(
    parameter int   DATA_WIDTH  = 16,
    parameter logic CSNPOL      = 1'b0,
    parameter logic CPOL        = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  csn,
    output logic [DATA_WIDTH-1:0] rdat,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] csn_sync_r;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   sck_d_r;

    state_t                 state_r;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [CW-1:0]          bitcnt_r;
    logic [DATA_WIDTH-1:0]  rdat_r;
    logic                   rvalid_r;
    logic                   busy_r;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic                   armed_r;

    logic                   sck_s;
    logic                   mosi_s;
    logic                   csn_act_s;
    logic                   capture_s;
    logic                   last_s;
    logic [DATA_WIDTH-1:0]  word_s;

    // Equal-depth synchronisers; fill_r marks when the chains hold real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_r  <= {SYNC_STAGES{~CPOL}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            csn_sync_r  <= {SYNC_STAGES{~CSNPOL}};
            fill_r      <= {SYNC_STAGES{1'b0}};
            sck_d_r     <= ~CPOL;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], csn};
            fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
        end
    end

    // Decode synchronised inputs into capture-edge and word-completion strobes.
    always_comb begin
        sck_s     = sck_sync_r[SYNC_STAGES-1];
        mosi_s    = mosi_sync_r[SYNC_STAGES-1];
        csn_act_s = (csn_sync_r[SYNC_STAGES-1] == CSNPOL);
        capture_s = 1'b0;
        if (csn_act_s && (sck_s == CPOL) && (sck_d_r != CPOL)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        last_s = (bitcnt_r == LAST_BIT);
        word_s = {shift_r[DATA_WIDTH-2:0], mosi_s};
    end

    // Receive FSM. armed_r blocks entry to RECV until csn has been seen
    // inactive after reset, so a reset mid-frame never resyncs mid-word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= {DATA_WIDTH{1'b0}};
            bitcnt_r    <= {CW{1'b0}};
            rdat_r      <= {DATA_WIDTH{1'b0}};
            rvalid_r    <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            if (fill_r[SYNC_STAGES-1] && !csn_act_s) begin
                armed_r <= 1'b1;
            end
            if (rvalid_r && rready) begin
                rvalid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (armed_r && csn_act_s) begin
                        state_r  <= RECV;
                        busy_r   <= 1'b1;
                        bitcnt_r <= {CW{1'b0}};
                        shift_r  <= {DATA_WIDTH{1'b0}};
                    end
                end
                RECV: begin
                    if (!csn_act_s) begin
                        // Release wins over a simultaneous capture edge.
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        frame_err_r <= (bitcnt_r != {CW{1'b0}});
                        bitcnt_r    <= {CW{1'b0}};
                        shift_r     <= {DATA_WIDTH{1'b0}};
                    end else if (capture_s) begin
                        shift_r <= word_s;
                        if (last_s) begin
                            bitcnt_r <= {CW{1'b0}};
                            if (!rvalid_r || rready) begin
                                rdat_r   <= word_s;
                                rvalid_r <= 1'b1;
                            end else begin
                                overrun_r <= 1'b1;
                            end
                        end else begin
                            bitcnt_r <= bitcnt_r + CW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rdat      = rdat_r;
    assign rvalid    = rvalid_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_spi_slave_read.sv
// Bench for spi_slave_read: two instances (16-bit CPOL=1/CSNPOL=0 and 8-bit
// CPOL=0/CSNPOL=1) share one bit stream; a word-chunking model predicts output.
module tb_spi_slave_read;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sck0, mosi, csn0, rready0, rready1;
    logic        sck1, csn1;
    logic [15:0] rdat0;
    logic [7:0]  rdat1;
    logic        rvalid0, rvalid1, busy0, busy1, ferr0, ferr1, ovr0, ovr1;

    assign sck1 = ~sck0;
    assign csn1 = ~csn0;

    spi_slave_read #(.DATA_WIDTH(16), .CSNPOL(1'b0), .CPOL(1'b1), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .sck(sck0), .mosi(mosi), .csn(csn0),
        .rdat(rdat0), .rvalid(rvalid0), .rready(rready0), .busy(busy0),
        .frame_err(ferr0), .overrun(ovr0));

    spi_slave_read #(.DATA_WIDTH(8), .CSNPOL(1'b1), .CPOL(1'b0), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .sck(sck1), .mosi(mosi), .csn(csn1),
        .rdat(rdat1), .rvalid(rvalid1), .rready(rready1), .busy(busy1),
        .frame_err(ferr1), .overrun(ovr1));

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] got0[$], exp0[$];
    logic [7:0]  got1[$], exp1[$];
    int ferr_cnt0 = 0, ferr_cnt1 = 0, ovr_cnt0 = 0, ovr_cnt1 = 0;
    int exp_ferr0 = 0, exp_ferr1 = 0, exp_ovr0 = 0, exp_ovr1 = 0;
    bit bits_q[$];
    logic [15:0] pend0;
    bit pend_v0 = 1'b0;

    always @(negedge clk) begin
        if (rvalid0 && rready0) got0.push_back(rdat0);
        if (rvalid1 && rready1) got1.push_back(rdat1);
        if (ferr0) ferr_cnt0++;
        if (ferr1) ferr_cnt1++;
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [31:0] w, input int nb);
        for (int i = nb - 1; i >= 0; i--) bits_q.push_back(w[i]);
    endtask

    function automatic logic [31:0] chunk(input int start, input int dw);
        logic [31:0] w = 32'd0;
        for (int j = 0; j < dw; j++) w = {w[30:0], 1'(bits_q[start + j])};
        return w;
    endfunction

    // Model: a frame of nb bits yields floor(nb/DW) words; leftovers are a frame error.
    task automatic model_frame(input int nb, input bit err_counts, input bit hold0);
        logic [31:0] w;
        for (int k = 0; k + 16 <= nb; k += 16) begin
            w = chunk(k, 16);
            if (!hold0) exp0.push_back(w[15:0]);
            else if (!pend_v0) begin pend0 = w[15:0]; pend_v0 = 1'b1; end
            else exp_ovr0++;
        end
        for (int k = 0; k + 8 <= nb; k += 8) begin
            w = chunk(k, 8);
            exp1.push_back(w[7:0]);
        end
        if (err_counts && (nb % 16 != 0)) exp_ferr0++;
        if (err_counts && (nb % 8 != 0)) exp_ferr1++;
    endtask

    task automatic frame_begin();
        csn0 = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            mosi = bits_q[i];
            wait_clk(4);
            sck0 = 1'b1;
            wait_clk(4);
            sck0 = 1'b0;
        end
    endtask

    task automatic frame_end();
        wait_clk(3);
        csn0 = 1'b1;
        wait_clk(6);
    endtask

    task automatic run_frame(input int nb, input bit hold0);
        frame_begin();
        send_range(0, nb);
        frame_end();
        model_frame(nb, 1'b1, hold0);
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_n0"}, got0.size(), exp0.size());
        if (got0.size() == exp0.size())
            foreach (exp0[i]) chk({tag, "_w0"}, got0[i], exp0[i]);
        chk({tag, "_n1"}, got1.size(), exp1.size());
        if (got1.size() == exp1.size())
            foreach (exp1[i]) chk({tag, "_w1"}, got1[i], exp1[i]);
        chk({tag, "_ferr0"}, ferr_cnt0, exp_ferr0);
        chk({tag, "_ferr1"}, ferr_cnt1, exp_ferr1);
        chk({tag, "_ovr0"}, ovr_cnt0, exp_ovr0);
        chk({tag, "_ovr1"}, ovr_cnt1, exp_ovr1);
        got0.delete(); exp0.delete(); got1.delete(); exp1.delete();
        bits_q.delete();
    endtask

    initial begin
        int nw, extra;
        rst = 1'b1; sck0 = 1'b0; csn0 = 1'b1; mosi = 1'b0;
        rready0 = 1'b1; rready1 = 1'b1;
        wait_clk(4);
        chk("rst_rdat0", rdat0, 16'h0000);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_ferr0", ferr0, 1'b0);
        chk("rst_ovr0", ovr0, 1'b0);
        chk("rst_rdat1", rdat1, 8'h00);
        chk("rst_rvalid1", rvalid1, 1'b0);
        rst = 1'b0;
        wait_clk(4);

        // Single word, with busy checked inside the frame
        push_word(32'h0000A5C3, 16);
        frame_begin();
        chk("busy0_in_frame", busy0, 1'b1);
        chk("busy1_in_frame", busy1, 1'b1);
        send_range(0, 16);
        frame_end();
        model_frame(16, 1'b1, 1'b0);
        chk("single_rdat0", rdat0, 16'hA5C3);
        chk("single_rvalid0", rvalid0, 1'b0);
        chk("idle_busy0", busy0, 1'b0);
        cmp_all("single");

        // Back-to-back words in one frame
        push_word(32'h00001234, 16);
        push_word(32'h0000FFFF, 16);
        run_frame(32, 1'b0);
        cmp_all("b2b");

        // Overrun: consumer stalled on the 16-bit instance
        rready0 = 1'b0;
        push_word(32'h00000001, 16);
        push_word(32'h00008000, 16);
        run_frame(32, 1'b1);
        chk("ovr_rvalid0", rvalid0, 1'b1);
        chk("ovr_rdat0", rdat0, pend0);
        rready0 = 1'b1;
        wait_clk(2);
        exp0.push_back(pend0);
        pend_v0 = 1'b0;
        chk("ovr_drained", rvalid0, 1'b0);
        cmp_all("overrun");

        // Aborted frame of 5 bits, then a full word
        push_word($urandom_range(0, 31), 5);
        run_frame(5, 1'b0);
        chk("abort_rvalid0", rvalid0, 1'b0);
        cmp_all("abort");
        push_word(32'h000000FF, 16);
        run_frame(16, 1'b0);
        cmp_all("after_abort");

        // Reset mid-frame with csn held active
        push_word($urandom_range(0, 65535), 16);
        frame_begin();
        send_range(0, 8);
        wait_clk(4);
        rst = 1'b1;
        wait_clk(2);
        chk("mrst_rdat0", rdat0, 16'h0000);
        chk("mrst_rvalid0", rvalid0, 1'b0);
        chk("mrst_busy0", busy0, 1'b0);
        chk("mrst_rdat1", rdat1, 8'h00);
        rst = 1'b0;
        send_range(8, 16);
        chk("mrst_stay_idle0", busy0, 1'b0);
        chk("mrst_stay_idle1", busy1, 1'b0);
        frame_end();
        model_frame(8, 1'b0, 1'b0);
        cmp_all("midrst");
        push_word(32'h0000BEEF, 16);
        run_frame(16, 1'b0);
        cmp_all("beef");

        // Byte on the inverted-polarity instance
        push_word(32'h0000005A, 8);
        run_frame(8, 1'b0);
        chk("pol_rdat1", rdat1, 8'h5A);
        cmp_all("polarity");

        // sck activity with csn inactive must be ignored
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sck0 = ~sck0;
            wait_clk(4);
        end
        sck0 = 1'b0;
        wait_clk(6);
        cmp_all("csn_idle");

        // Random frames, some ending with a partial word
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(1, 3);
            extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
            for (int k = 0; k < nw; k++) push_word($urandom_range(0, 65535), 16);
            if (extra != 0) push_word($urandom, extra);
            run_frame(nw * 16 + extra, 1'b0);
            cmp_all("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
